pad_mux_cfg_ctrl: RTL
=====================

Name: pad_mux_cfg_ctrl

Overview:
Configuration controller that generates the per-pad func_sel, test_sel and func_test_sel select buses consumed by the pad mux top. Software or test logic writes per-pad selections into staging registers through a valid/ready write port. A commit then moves all staged values to the live select outputs in one atomic step. During the update a pad-hold window is asserted so downstream pad logic can freeze and no glitching selection reaches the pins.

Parameters:
NUM_PADS, 10, number of pad mux instances driven
FUNC_SEL_W, 2, func_sel bits per pad
TEST_SEL_W, 4, test_sel bits per pad
IDX_W, 4, width of pad index (2**IDX_W >= NUM_PADS)
HOLD_CYCLES, 4, length of pre- and post-apply hold windows (>=1)

Ports:
i_clk  input  1  clock
i_rst  input  1  reset, asynchronous, active-high
i_wr_valid  input  1  write request
o_wr_ready  output  1  write accept (IDLE only)
i_wr_idx  input  IDX_W  target pad index
i_wr_func_sel  input  FUNC_SEL_W  staged func_sel value
i_wr_test_sel  input  TEST_SEL_W  staged test_sel value
i_wr_ft_sel  input  1  staged func_test_sel (0 = functional, 1 = test)
o_wr_err  output  1  one-cycle pulse: accepted write had idx >= NUM_PADS
i_commit  input  1  commit request pulse
o_busy  output  1  commit sequence in progress
o_pad_hold  output  1  hold window to pad logic
o_done  output  1  one-cycle pulse at commit completion
o_pending  output  1  staging differs from live (written since last apply)
i_rd_idx  input  IDX_W  readback pad index
o_rd_data  output  FUNC_SEL_W+TEST_SEL_W+1  registered live value {ft,test,func} of i_rd_idx
func_sel  output  NUM_PADS*FUNC_SEL_W  live func_sel, pad n at [n*FUNC_SEL_W +: FUNC_SEL_W]
test_sel  output  NUM_PADS*TEST_SEL_W  live test_sel, pad n at [n*TEST_SEL_W +: TEST_SEL_W]
func_test_sel  output  NUM_PADS  live func_test_sel, pad n at bit n

Behaviour:
- Reset (async, immediate, also mid-sequence):
  - staging and live all 0, which selects function 0, test 0 and functional mode.
  - o_busy=0, o_pad_hold=0, o_done=0, o_wr_err=0, o_pending=0, o_rd_data=0.
  - o_wr_ready=1 once reset deasserts. State returns to IDLE.
- FSM states: IDLE, HOLD_PRE, APPLY, HOLD_POST. Down-counter of width clog2(HOLD_CYCLES+1).
  - IDLE: o_wr_ready=1. i_commit=1 -> HOLD_PRE, counter loaded with HOLD_CYCLES.
  - HOLD_PRE: counter decrements each cycle. After HOLD_CYCLES cycles -> APPLY.
  - APPLY: single cycle. All staging copied to live at the end of the cycle. o_pending cleared. Counter reloaded. -> HOLD_POST.
  - HOLD_POST: after HOLD_CYCLES cycles -> IDLE, with o_done pulsed in the first IDLE cycle.
- Handshake and outputs during a sequence:
  - o_busy and o_pad_hold are registered, high in every non-IDLE state.
  - o_wr_ready=0 outside IDLE. i_wr_valid there is not accepted; the requester holds it until ready.
  - i_commit outside IDLE is ignored (not queued).
- Writes: a write is accepted when i_wr_valid & o_wr_ready at the clock edge.
  - Valid idx: staging[idx] updated and o_pending set.
  - idx >= NUM_PADS: no state change; o_wr_err pulses the next cycle.
- Write and commit in the same IDLE cycle: the write is accepted and included in that commit.
- Commit with o_pending=0 runs the full sequence anyway; live values are unchanged.
- Live outputs change only at the APPLY edge. All pads update in the same cycle; no partial update is visible.
- Timing (commit sampled at edge of cycle 0, H=HOLD_CYCLES):
  - HOLD_PRE: cycles 1..H
  - APPLY: cycle H+1
  - new live values visible: cycle H+2
  - HOLD_POST: cycles H+2..2H+1
  - o_done and o_wr_ready high: cycle 2H+2
- Readback: o_rd_data registers the live value of i_rd_idx one cycle after sampling. idx >= NUM_PADS returns 0.
- Reset mid-sequence: live returns to 0 even if APPLY had not occurred; no o_done is generated.

Test Plan:
- Reset release -> func_sel=0, test_sel=0, func_test_sel=0, o_wr_ready=1, o_busy=0, o_rd_data=0.
- Write pad 3 {func=2, test=9, ft=1}, commit at cycle 0 with H=4:
  - o_pad_hold high cycles 1..9; func_sel[7:6]=2, test_sel[15:12]=9, func_test_sel[3]=1 from cycle 6.
  - o_done pulse at cycle 10; o_pending 1 -> 0 at cycle 6.
- i_wr_valid held during HOLD_PRE with idx=5 -> not accepted until cycle 10. The pad 5 value stays staged, o_pending=1, and live is unchanged.
- Write idx=12 (NUM_PADS=10) -> o_wr_err one-cycle pulse, o_pending stays 0, staging unchanged. Readback idx=12 -> 0.
- Write pad 0 func=1 together with i_commit in the same cycle -> func_sel[1:0]=1 at cycle 6. A second i_commit at cycle 3 is ignored (single o_done).
- Stage pads 0..9, commit, assert i_rst at cycle 3 (HOLD_PRE) -> all outputs 0 immediately, no o_done, staging cleared.

Source files
------------

// File: rtl/pad_mux_cfg_ctrl_if.sv
// Write, commit, status, readback and live select bundle between the pad-mux
// configuration controller and its software or test-logic requester.
interface pad_mux_cfg_ctrl_if #(
  parameter int NUM_PADS   = 10,
  parameter int FUNC_SEL_W = 2,
  parameter int TEST_SEL_W = 4,
  parameter int IDX_W      = 4
);
  logic                                i_wr_valid;
  logic                                o_wr_ready;
  logic [IDX_W-1:0]                    i_wr_idx;
  logic [FUNC_SEL_W-1:0]               i_wr_func_sel;
  logic [TEST_SEL_W-1:0]               i_wr_test_sel;
  logic                                i_wr_ft_sel;
  logic                                o_wr_err;
  logic                                i_commit;
  logic                                o_busy;
  logic                                o_pad_hold;
  logic                                o_done;
  logic                                o_pending;
  logic [IDX_W-1:0]                    i_rd_idx;
  logic [FUNC_SEL_W+TEST_SEL_W:0]      o_rd_data;
  logic [NUM_PADS*FUNC_SEL_W-1:0]      func_sel;
  logic [NUM_PADS*TEST_SEL_W-1:0]      test_sel;
  logic [NUM_PADS-1:0]                 func_test_sel;

  modport master (
    output i_wr_valid, i_wr_idx, i_wr_func_sel, i_wr_test_sel, i_wr_ft_sel,
    output i_commit, i_rd_idx,
    input  o_wr_ready, o_wr_err, o_busy, o_pad_hold, o_done, o_pending,
    input  o_rd_data, func_sel, test_sel, func_test_sel
  );

  modport slave (
    input  i_wr_valid, i_wr_idx, i_wr_func_sel, i_wr_test_sel, i_wr_ft_sel,
    input  i_commit, i_rd_idx,
    output o_wr_ready, o_wr_err, o_busy, o_pad_hold, o_done, o_pending,
    output o_rd_data, func_sel, test_sel, func_test_sel
  );
endinterface

// File: rtl/pad_mux_cfg_ctrl.sv
// Pad-mux select controller: per-pad staging registers, atomic commit to the
// live select buses, framed by pad-hold windows before and after the apply.
module pad_mux_cfg_ctrl #(
  parameter int NUM_PADS    = 10,
  parameter int FUNC_SEL_W  = 2,
  parameter int TEST_SEL_W  = 4,
  parameter int IDX_W       = 4,
  parameter int HOLD_CYCLES = 4
) (
  input  logic            i_clk,
  input  logic            i_rst,
  pad_mux_cfg_ctrl_if.slave bus
);
  localparam int CNT_W = $clog2(HOLD_CYCLES + 1);
  localparam int RD_W  = FUNC_SEL_W + TEST_SEL_W + 1;
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(1);
  localparam logic [IDX_W:0]   PAD_LIMIT = (IDX_W + 1)'(NUM_PADS);

  typedef enum logic [1:0] {IDLE, HOLD_PRE, APPLY, HOLD_POST} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [FUNC_SEL_W-1:0] stg_func  [NUM_PADS];
  logic [TEST_SEL_W-1:0] stg_test  [NUM_PADS];
  logic                  stg_ft    [NUM_PADS];
  logic [FUNC_SEL_W-1:0] live_func [NUM_PADS];
  logic [TEST_SEL_W-1:0] live_test [NUM_PADS];
  logic                  live_ft   [NUM_PADS];

  logic            busy_q, done_q, err_q, pending_q;
  logic [RD_W-1:0] rd_q, rd_d;
  logic            wr_ready, wr_fire, wr_idx_ok, apply_now;

  assign wr_ready  = (state_q == IDLE);
  assign wr_fire   = bus.i_wr_valid & wr_ready;
  assign wr_idx_ok = ({1'b0, bus.i_wr_idx} < PAD_LIMIT);
  assign apply_now = (state_q == APPLY);

  // NOTE: every signal driven here gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (bus.i_commit) begin
          state_d = HOLD_PRE;
          cnt_d   = HOLD_LOAD;
        end
      end
      HOLD_PRE: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_LAST) state_d = APPLY;
      end
      APPLY: begin
        state_d = HOLD_POST;
        cnt_d   = HOLD_LOAD;
      end
      HOLD_POST: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_LAST) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rd_d = '0;
    for (int p = 0; p < NUM_PADS; p++) begin
      if (bus.i_rd_idx == IDX_W'(p)) rd_d = {live_ft[p], live_test[p], live_func[p]};
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops see pre-edge values.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      pending_q <= 1'b0;
      rd_q      <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= (state_d != IDLE);
      done_q  <= (state_q == HOLD_POST) && (state_d == IDLE);
      err_q   <= wr_fire & ~wr_idx_ok;
      rd_q    <= rd_d;
      if (apply_now)                 pending_q <= 1'b0;
      else if (wr_fire && wr_idx_ok) pending_q <= 1'b1;
    end
  end

  // NOTE: staging and live arrays are reset on purpose: a reset pad must select
  // function 0 in functional mode, so these cannot be left uninitialised like plain RAM.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int p = 0; p < NUM_PADS; p++) begin
        stg_func[p]  <= '0;
        stg_test[p]  <= '0;
        stg_ft[p]    <= 1'b0;
        live_func[p] <= '0;
        live_test[p] <= '0;
        live_ft[p]   <= 1'b0;
      end
    end else begin
      for (int p = 0; p < NUM_PADS; p++) begin
        if (wr_fire && bus.i_wr_idx == IDX_W'(p)) begin
          stg_func[p] <= bus.i_wr_func_sel;
          stg_test[p] <= bus.i_wr_test_sel;
          stg_ft[p]   <= bus.i_wr_ft_sel;
        end
        // Writes are only accepted in IDLE, so they never collide with the apply copy.
        if (apply_now) begin
          live_func[p] <= stg_func[p];
          live_test[p] <= stg_test[p];
          live_ft[p]   <= stg_ft[p];
        end
      end
    end
  end

  for (genvar p = 0; p < NUM_PADS; p++) begin : g_flat
    assign bus.func_sel[p*FUNC_SEL_W +: FUNC_SEL_W] = live_func[p];
    assign bus.test_sel[p*TEST_SEL_W +: TEST_SEL_W] = live_test[p];
    assign bus.func_test_sel[p]                     = live_ft[p];
  end

  assign bus.o_wr_ready = wr_ready;
  assign bus.o_wr_err   = err_q;
  assign bus.o_busy     = busy_q;
  assign bus.o_pad_hold = busy_q;
  assign bus.o_done     = done_q;
  assign bus.o_pending  = pending_q;
  assign bus.o_rd_data  = rd_q;
endmodule
